// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump sequencer.
// Optional macro REGDUMP_NAME_EN adds an ABI register-name field to each record.
package regdump_pkg;

   localparam int REG_IDX_W  = 5;               // default register index width
   localparam int REG_XLEN   = 64;              // default register data width
   localparam int NUM_REGS   = 2 ** REG_IDX_W;  // registers walked per dump
   localparam int ABI_NAME_W = 4 * 8;           // four ASCII characters, MSB-first
   localparam int LAT_CNT_W  = 3;               // holds read latencies 1..4

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      READ,
      WAIT,
      SEND,
      RELEASE
   } state_t;

   // One trace record as seen by the sink.
   typedef struct packed {
      logic [REG_IDX_W-1:0] reg_num;
      logic [REG_XLEN-1:0]  reg_data;
   } record_t;

endpackage

// File: rtl/regdump_if.sv
// Bundle of the sequencer's debug-control, halt, RF read and record-stream signals.
// Macro REGDUMP_NAME_EN adds out_reg_name to the record stream.
interface regdump_if
   import regdump_pkg::*;
#(
   parameter int REGISTER_WIDTH = REG_IDX_W,
   parameter int XLEN           = REG_XLEN
);

   // debug control
   logic                      dump_start;
   logic                      dump_busy;
   logic                      dump_done;
   logic                      dump_err;
   // core halt handshake
   logic                      halt_req;
   logic                      halt_ack;
   // shared register-file read port
   logic                      rf_rd_en;
   logic [REGISTER_WIDTH-1:0] rf_rd_addr;
   logic [XLEN-1:0]           rf_rd_data;
   // record stream to the trace sink
   logic                      out_valid;
   logic                      out_ready;
   logic [REGISTER_WIDTH-1:0] out_reg_num;
   logic [XLEN-1:0]           out_reg_data;
`ifdef REGDUMP_NAME_EN
   logic [ABI_NAME_W-1:0]     out_reg_name;
`endif

   // The sequencer side.
   modport master (
      input  dump_start, halt_ack, rf_rd_data, out_ready,
      output dump_busy, dump_done, dump_err, halt_req,
             rf_rd_en, rf_rd_addr, out_valid, out_reg_num, out_reg_data
`ifdef REGDUMP_NAME_EN
    , output out_reg_name
`endif
   );

   // The debug logic, core, register file and sink side.
   modport slave (
      output dump_start, halt_ack, rf_rd_data, out_ready,
      input  dump_busy, dump_done, dump_err, halt_req,
             rf_rd_en, rf_rd_addr, out_valid, out_reg_num, out_reg_data
`ifdef REGDUMP_NAME_EN
    , input  out_reg_name
`endif
   );

endinterface

// File: rtl/regdump_name_rom.sv
// Combinational register index to RISC-V ABI name lookup (right-aligned, zero-padded ASCII).
// Only instantiated when REGDUMP_NAME_EN is defined.
module regdump_name_rom
   import regdump_pkg::*;
#(
   parameter int REGISTER_WIDTH = REG_IDX_W
) (
   input  logic [REGISTER_WIDTH-1:0] idx,
   output logic [ABI_NAME_W-1:0]     name
);

   // Standard ABI mapping; indices beyond x31 read back as "????".
   always_comb begin
      name = "????";
      case (int'(idx))
         0:  name = "zero";
         1:  name = {16'h0, "ra"};
         2:  name = {16'h0, "sp"};
         3:  name = {16'h0, "gp"};
         4:  name = {16'h0, "tp"};
         5:  name = {16'h0, "t0"};
         6:  name = {16'h0, "t1"};
         7:  name = {16'h0, "t2"};
         8:  name = {16'h0, "s0"};
         9:  name = {16'h0, "s1"};
         10: name = {16'h0, "a0"};
         11: name = {16'h0, "a1"};
         12: name = {16'h0, "a2"};
         13: name = {16'h0, "a3"};
         14: name = {16'h0, "a4"};
         15: name = {16'h0, "a5"};
         16: name = {16'h0, "a6"};
         17: name = {16'h0, "a7"};
         18: name = {16'h0, "s2"};
         19: name = {16'h0, "s3"};
         20: name = {16'h0, "s4"};
         21: name = {16'h0, "s5"};
         22: name = {16'h0, "s6"};
         23: name = {16'h0, "s7"};
         24: name = {16'h0, "s8"};
         25: name = {16'h0, "s9"};
         26: name = {8'h0, "s10"};
         27: name = {8'h0, "s11"};
         28: name = {16'h0, "t3"};
         29: name = {16'h0, "t4"};
         30: name = {16'h0, "t5"};
         31: name = {16'h0, "t6"};
         default: name = "????";
      endcase
   end

endmodule

// File: rtl/regfile_dump_sequencer.sv
// Debug dump sequencer: halts the core, reads every architectural register through the
// shared RF read port one at a time and streams (index, value) records to the trace sink.
// Macro REGDUMP_NAME_EN adds the registered out_reg_name field (ABI name of out_reg_num).
module regfile_dump_sequencer
   import regdump_pkg::*;
#(
   parameter int REGISTER_WIDTH = REG_IDX_W,
   parameter int XLEN           = REG_XLEN,
   parameter int RD_LATENCY     = 1
) (
   input  logic      clk,
   input  logic      reset,
   regdump_if.master bus
);

   localparam logic [REGISTER_WIDTH-1:0] LAST_IDX = '1;
   localparam logic [LAT_CNT_W-1:0]      LAT_LOAD = LAT_CNT_W'(RD_LATENCY);
   localparam logic [LAT_CNT_W-1:0]      LAT_LAST = LAT_CNT_W'(1);

   state_t                    state, state_nxt;
   logic [REGISTER_WIDTH-1:0] idx, idx_nxt;
   logic [LAT_CNT_W-1:0]      lat_cnt, lat_cnt_nxt;
   logic                      capture;
   logic                      done_nxt, err_nxt;
   logic                      done_q, err_q;
   logic [REGISTER_WIDTH-1:0] rec_num;
   logic [XLEN-1:0]           rec_data;

   // Next-state, walk index and latency bookkeeping.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves a latch.
      state_nxt   = state;
      idx_nxt     = idx;
      lat_cnt_nxt = lat_cnt;
      capture     = 1'b0;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;

      case (state)
         IDLE:    if (bus.dump_start) state_nxt = HALT;
         HALT:    if (bus.halt_ack) state_nxt = READ;
         READ: begin
            lat_cnt_nxt = LAT_LOAD;
            state_nxt   = WAIT;
         end
         WAIT: begin
            lat_cnt_nxt = lat_cnt - 1'b1;
            if (lat_cnt == LAT_LAST) begin
               capture   = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               if (idx == LAST_IDX) begin
                  state_nxt = RELEASE;
               end else begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = READ;
               end
            end
         end
         RELEASE: begin
            if (!bus.halt_ack) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase

      // The core took the read port back mid-walk: drop everything. A handshake in this
      // same cycle has already been seen by the sink, but the dump still ends in error.
      if ((state inside {READ, WAIT, SEND}) && !bus.halt_ack) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         err_nxt   = 1'b1;
      end
   end

   // Control state and the one-cycle done/error pulses.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         lat_cnt <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         lat_cnt <= lat_cnt_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
      end
   end

   // Record register: loaded in the cycle the RF data is valid, held through SEND.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the record is reset too, so every output reads 0 straight out of reset.
      if (reset) begin
         rec_num  <= '0;
         rec_data <= '0;
      end else if (capture) begin
         rec_num  <= idx;
         rec_data <= bus.rf_rd_data;
      end
   end

`ifdef REGDUMP_NAME_EN
   logic [ABI_NAME_W-1:0] rom_name;
   logic [ABI_NAME_W-1:0] rec_name;

   regdump_name_rom #(
      .REGISTER_WIDTH(REGISTER_WIDTH)
   ) u_name_rom (
      .idx  (idx),
      .name (rom_name)
   );

   // ABI name travels with the record so it shares its timing and stability.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rec_name <= '0;
      end else if (capture) begin
         rec_name <= rom_name;
      end
   end

   assign bus.out_reg_name = rec_name;
`endif

   // Outputs decode from state; the RF port is only driven while we own it.
   assign bus.dump_busy    = (state != IDLE);
   assign bus.halt_req     = (state inside {HALT, READ, WAIT, SEND});
   assign bus.rf_rd_en     = (state == READ);
   assign bus.rf_rd_addr   = (state == READ) ? idx : '0;
   assign bus.out_valid    = (state == SEND);
   assign bus.out_reg_num  = rec_num;
   assign bus.out_reg_data = rec_data;
   assign bus.dump_done    = done_q;
   assign bus.dump_err     = err_q;

endmodule
